// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Definitions shared by the ALU receive-side blocks:
//     ALU_WIDTH   - default operand width
//     rcv_state_t - receive FSM state encoding (IDLE=0, COUNT=1, DONE=2)
//     cnt_w()     - width needed to hold a count from 0 to w inclusive
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_DONE  = 2'd2
  } rcv_state_t;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/bit_serial_popcount.sv
// ---------------------------------------------------------------------------
// bit_serial_popcount
//   Counts the 1 bits of a word, one bit per clock, LSB first.
//   Ports:
//     clk, rst  - clock, synchronous active-high reset
//     load      - capture data and clear the count / bit index
//     en        - advance one bit this cycle
//     data      - word to count
//     cnt       - running count including the bit currently at shreg[0]
//     done      - high on the cycle whose edge consumes the last bit;
//                 cnt is the final popcount in that cycle
// ---------------------------------------------------------------------------
module bit_serial_popcount #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] data,
  output logic [CNT_W-1:0] cnt,
  output logic             done
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0] shreg;
  logic [IDX_W-1:0] idx;
  logic [CNT_W-1:0] acc;

  // cnt already includes the bit being consumed, so the owner can latch the
  // final value on the same edge that consumes the last bit.
  assign cnt  = acc + CNT_W'(shreg[0]);
  assign done = en && (idx == IDX_W'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg <= '0;
      idx   <= '0;
      acc   <= '0;
    end else if (load) begin
      shreg <= data;
      idx   <= '0;
      acc   <= '0;
    end else if (en) begin
      shreg <= shreg >> 1;
      idx   <= idx + IDX_W'(1);
      acc   <= cnt;
    end
  end

endmodule

// File: rtl/xnor_operand_recover.sv
// ---------------------------------------------------------------------------
// xnor_operand_recover
//   Receive side of the ALU bitwise-XNOR path. Given X = XNOR(A, B) and the
//   known operand A, recovers B = ~(X ^ A), counts the matching bit
//   positions (popcount of X) bit-serially, and returns the result over a
//   valid/ready handshake.
//   Ports:
//     clk, rst        - clock, synchronous active-high reset
//     in_valid/ready  - input handshake; in_ready only while idle
//     in_x, in_a      - XNOR result word and known operand A
//     out_valid/ready - output handshake; result held until taken
//     out_b           - recovered operand B
//     out_match_cnt   - number of 1 bits in X
//     out_equal       - all bits match (A == B)
//     words_done      - results consumed, wraps modulo 2^16
// ---------------------------------------------------------------------------
module xnor_operand_recover
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int CNT_W = cnt_w(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_x,
  input  logic [WIDTH-1:0] in_a,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_b,
  output logic [CNT_W-1:0] out_match_cnt,
  output logic             out_equal,
  output logic [15:0]      words_done
);

  rcv_state_t       state;
  logic             pc_load;
  logic             pc_en;
  logic [CNT_W-1:0] pc_cnt;
  logic             pc_done;

  assign in_ready = (state == ST_IDLE) && !rst;
  assign pc_load  = in_valid && in_ready;
  assign pc_en    = (state == ST_COUNT);

  bit_serial_popcount #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_popcount (
    .clk  (clk),
    .rst  (rst),
    .load (pc_load),
    .en   (pc_en),
    .data (in_x),
    .cnt  (pc_cnt),
    .done (pc_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_IDLE;
      out_valid     <= 1'b0;
      out_b         <= '0;
      out_match_cnt <= '0;
      out_equal     <= 1'b0;
      words_done    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pc_load) begin
            out_b <= ~(in_x ^ in_a);
            state <= ST_COUNT;
          end
        end
        ST_COUNT: begin
          if (pc_done) begin
            out_match_cnt <= pc_cnt;
            out_equal     <= (pc_cnt == CNT_W'(WIDTH));
            out_valid     <= 1'b1;
            state         <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_valid && out_ready) begin
            out_valid  <= 1'b0;
            words_done <= words_done + 16'd1;
            state      <= ST_IDLE;
          end
        end
        default: begin
          // Unused encoding: recover to idle without presenting a result.
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xnor_operand_recover.sv
module tb_xnor_operand_recover;

  localparam int WIDTH = 16;
  localparam int CNT_W = 5;

  typedef struct {
    logic [WIDTH-1:0] b;
    logic [CNT_W-1:0] cnt;
    logic             eq;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_x;
  logic [WIDTH-1:0] in_a;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_b;
  logic [CNT_W-1:0] out_match_cnt;
  logic             out_equal;
  logic [15:0]      words_done;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_wd = 16'd0;

  xnor_operand_recover dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_x          (in_x),
    .in_a          (in_a),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_b         (out_b),
    .out_match_cnt (out_match_cnt),
    .out_equal     (out_equal),
    .words_done    (words_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] a);
    exp_t e;
    e.b   = ~(x ^ a);
    e.cnt = CNT_W'($countones(x));
    e.eq  = ($countones(x) == WIDTH);
    return e;
  endfunction

  // Present a word, push its expected result, wait for the accepting edge.
  // in_valid is left high; the caller drops or changes it.
  task automatic accept(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] a);
    int n;
    in_x     = x;
    in_a     = a;
    in_valid = 1'b1;
    sb.push_back(model(x, a));
    n = 0;
    while (!in_ready && n < 100) begin
      tick();
      n++;
    end
    if (n >= 100) chk("accept_timeout", 32'(n), 32'd0);
    tick();
  endtask

  // Wait for the result after an accept, check latency and payload, hold
  // back-pressure for 'hold' cycles, then consume it.
  task automatic collect(input string tag, input int hold);
    int           n;
    logic         busy_bad;
    logic         hold_bad;
    exp_t         e;
    logic [WIDTH-1:0] sb_b;
    logic [CNT_W-1:0] sc;
    logic         se;
    n = 1;
    busy_bad = 1'b0;
    while (!out_valid && n <= 40) begin
      if (in_ready) busy_bad = 1'b1;
      tick();
      if (!out_valid) n++;
    end
    if (!out_valid) begin
      chk({tag, "_valid_timeout"}, 32'(out_valid), 32'd1);
      return;
    end
    chk({tag, "_latency"}, 32'(n), 32'(WIDTH));
    chk({tag, "_busy_in_ready"}, 32'(busy_bad), 32'd0);
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
      return;
    end
    e = sb.pop_front();
    chk({tag, "_b"}, 32'(out_b), 32'(e.b));
    chk({tag, "_cnt"}, 32'(out_match_cnt), 32'(e.cnt));
    chk({tag, "_eq"}, 32'(out_equal), 32'(e.eq));
    sb_b = out_b;
    sc = out_match_cnt;
    se = out_equal;
    hold_bad = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (!out_valid || in_ready || out_b !== sb_b || out_match_cnt !== sc ||
          out_equal !== se || words_done !== exp_wd)
        hold_bad = 1'b1;
    end
    if (hold > 0) chk({tag, "_hold_stable"}, 32'(hold_bad), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_wd = exp_wd + 16'd1;
    chk({tag, "_consumed_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_words_done"}, 32'(words_done), 32'(exp_wd));
    chk({tag, "_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    in_a      = '0;
    out_ready = 1'b0;

    // Reset state
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_b", 32'(out_b), 32'd0);
    chk("rst_cnt", 32'(out_match_cnt), 32'd0);
    chk("rst_eq", 32'(out_equal), 32'd0);
    chk("rst_words_done", 32'(words_done), 32'd0);
    rst = 1'b0;
    #1;
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // 1: basic word
    accept(16'hFFF7, 16'h1559);
    in_valid = 1'b0;
    chk("t1_in_ready_drop", 32'(in_ready), 32'd0);
    collect("t1", 0);

    // 2: all-ones and all-zeros X
    accept(16'hFFFF, 16'hA5A5);
    in_valid = 1'b0;
    collect("t2a", 0);
    accept(16'h0000, 16'h0000);
    in_valid = 1'b0;
    collect("t2b", 0);

    // 3: 40 cycles of back-pressure
    accept(16'h3C5A, 16'h0F0F);
    in_valid = 1'b0;
    collect("t3", 40);

    // 4: second word held on in_valid while busy
    accept(16'h1234, 16'hBEEF);
    in_x = 16'hF0F1;
    in_a = 16'h7777;
    sb.push_back(model(16'hF0F1, 16'h7777));
    collect("t4a", 3);
    tick();
    in_valid = 1'b0;
    collect("t4b", 0);

    // 5: reset during COUNT discards the pending word
    accept(16'hAAAA, 16'h5555);
    in_valid = 1'b0;
    repeat (7) tick();
    rst = 1'b1;
    tick();
    chk("t5_in_ready_in_rst", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    void'(sb.pop_back());
    exp_wd = 16'd0;
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    chk("t5_words_done", 32'(words_done), 32'd0);
    chk("t5_out_b", 32'(out_b), 32'd0);
    accept(16'h8001, 16'h00FF);
    in_valid = 1'b0;
    collect("t5_fresh", 0);

    // 6: words_done wrap
    force dut.words_done = 16'hFFFE;
    #1;
    release dut.words_done;
    exp_wd = 16'hFFFE;
    chk("t6_preload", 32'(words_done), 32'h0000FFFE);
    accept(16'h7FFF, 16'h1111);
    in_valid = 1'b0;
    collect("t6_ffff", 0);
    accept(16'h0001, 16'h2222);
    in_valid = 1'b0;
    collect("t6_wrap", 0);
    chk("t6_wrap_zero", 32'(words_done), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
